// File: rtl/qdiv_defs.sv
// Shared constants and FSM encoding for the sequential Q-format divider.
package qdiv_defs;
   localparam int DATA_W = 16;
   localparam int OUT_W  = 32;
   localparam int ITER   = 32;
   localparam int CNT_W  = $clog2(ITER);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } qdiv_state_e;
endpackage

// File: rtl/qdiv_seq_sat.sv
// Signed clamp of a value to [i_min, i_max]; purely combinational.
module qdiv_seq_sat
   import qdiv_defs::*;
(
   input  logic signed [OUT_W-1:0] i_din,
   input  logic signed [OUT_W-1:0] i_max,
   input  logic signed [OUT_W-1:0] i_min,
   output logic signed [OUT_W-1:0] o_dout
);

   always_comb begin
      o_dout = i_din;
      if (i_din > i_max) begin
         o_dout = i_max;
      end else if (i_din < i_min) begin
         o_dout = i_min;
      end
   end

endmodule

// File: rtl/qdiv_seq.sv
// Sequential signed divider: result = (a << q_shift) / b, one quotient bit per cycle, clamped.
// Build option: define QDIV_ROUND_EN for round-half-away-from-zero instead of truncation.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// in_ready is high only in IDLE, out_valid only in DONE, and DONE outputs hold until out_ready.
module qdiv_seq
   import qdiv_defs::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic [3:0]               q_shift,
   input  logic signed [OUT_W-1:0]  sat_max,
   input  logic signed [OUT_W-1:0]  sat_min,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  result,
   output logic                     div_by_zero,
   output logic                     saturated,
   output qdiv_state_e              dbg_state
);

   qdiv_state_e r_state;
   qdiv_state_e w_state_nx;

   logic                    r_sign;
   logic [ITER-1:0]         r_div;
   logic [DATA_W:0]         r_bmag;
   logic [DATA_W-1:0]       r_rem;
   logic [CNT_W-1:0]        r_cnt;
   logic signed [OUT_W-1:0] r_sat_max;
   logic signed [OUT_W-1:0] r_sat_min;
   logic signed [OUT_W-1:0] r_result;
   logic                    r_dbz;
   logic                    r_satd;

   logic [DATA_W:0]         w_a_ext;
   logic [DATA_W:0]         w_b_ext;
   logic [DATA_W:0]         w_amag;
   logic [DATA_W:0]         w_bmag;
   logic [ITER-1:0]         w_dvd_init;
   logic                    w_b_zero;
   logic signed [OUT_W-1:0] w_zero_res;
   logic [DATA_W:0]         w_rem_sh;
   logic                    w_ge;
   logic [DATA_W-1:0]       w_rem_nx;
   logic [ITER-1:0]         w_quo_nx;
   logic                    w_last;
   logic                    w_round_up;
   logic [OUT_W-1:0]        w_qmag;
   logic signed [OUT_W-1:0] w_q_signed;
   logic signed [OUT_W-1:0] w_q_sat;
   logic                    w_satd;

   // Magnitudes carry one extra bit so that -2^(DATA_W-1) is representable.
   assign w_a_ext    = {a[DATA_W-1], a};
   assign w_b_ext    = {b[DATA_W-1], b};
   assign w_amag     = a[DATA_W-1] ? (~w_a_ext + (DATA_W+1)'(1)) : w_a_ext;
   assign w_bmag     = b[DATA_W-1] ? (~w_b_ext + (DATA_W+1)'(1)) : w_b_ext;
   assign w_dvd_init = ITER'(w_amag) << q_shift;
   assign w_b_zero   = (b == '0);
   assign w_zero_res = a[DATA_W-1] ? sat_min : sat_max;

   // Restoring step: the remainder stays below |b|, so DATA_W bits hold it between steps.
   assign w_rem_sh = {r_rem, r_div[ITER-1]};
   assign w_ge     = (w_rem_sh >= r_bmag);
   assign w_rem_nx = w_ge ? DATA_W'(w_rem_sh - r_bmag) : DATA_W'(w_rem_sh);
   assign w_quo_nx = {r_div[ITER-2:0], w_ge};
   assign w_last   = (r_cnt == CNT_W'(ITER-1));

`ifdef QDIV_ROUND_EN
   assign w_round_up = ({w_rem_nx, 1'b0} >= r_bmag);
`else
   assign w_round_up = 1'b0;
`endif

   assign w_qmag     = OUT_W'(w_quo_nx) + OUT_W'(w_round_up);
   assign w_q_signed = r_sign ? (~w_qmag + OUT_W'(1)) : w_qmag;

   qdiv_seq_sat u_sat (
      .i_din  (w_q_signed),
      .i_max  (r_sat_max),
      .i_min  (r_sat_min),
      .o_dout (w_q_sat)
   );

   assign w_satd = (w_q_sat != w_q_signed);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nx = w_b_zero ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (w_last) begin
               w_state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nx = ST_IDLE;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sign    <= 1'b0;
         r_div     <= '0;
         r_bmag    <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_sat_max <= '0;
         r_sat_min <= '0;
         r_result  <= '0;
         r_dbz     <= 1'b0;
         r_satd    <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_sign    <= a[DATA_W-1] ^ b[DATA_W-1];
                  r_sat_max <= sat_max;
                  r_sat_min <= sat_min;
                  r_bmag    <= w_bmag;
                  r_div     <= w_dvd_init;
                  r_rem     <= '0;
                  r_cnt     <= '0;
                  if (w_b_zero) begin
                     r_result <= w_zero_res;
                     r_dbz    <= 1'b1;
                     r_satd   <= 1'b1;
                  end
               end
            end
            ST_CALC: begin
               r_rem <= w_rem_nx;
               r_div <= w_quo_nx;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_result <= w_q_sat;
                  r_dbz    <= 1'b0;
                  r_satd   <= w_satd;
               end
            end
            default: ;
         endcase
      end
   end

   assign result      = r_result;
   assign div_by_zero = r_dbz;
   assign saturated   = r_satd;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_qdiv_seq.sv
// Scoreboard bench for qdiv_seq: directed operations with hand-computed quotients.
module tb_qdiv_seq;
   import qdiv_defs::*;

`ifdef QDIV_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   localparam logic signed [31:0] S_MAX = 32'sh7fffffff;
   localparam logic signed [31:0] S_MIN = 32'sh80000000;
   localparam int EXP_W = 34;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] a = '0;
   logic signed [15:0] b = '0;
   logic [3:0]         q_shift = '0;
   logic signed [31:0] sat_max = '0;
   logic signed [31:0] sat_min = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [31:0] result;
   logic               div_by_zero;
   logic               saturated;
   qdiv_state_e        dbg_state;

   logic [EXP_W-1:0] exp_q[$];
   int               acc_q[$];
   int               lat_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int first_cyc = 0;
   bit seen_valid = 1'b0;

   qdiv_seq dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .q_shift     (q_shift),
      .sat_max     (sat_max),
      .sat_min     (sat_min),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .div_by_zero (div_by_zero),
      .saturated   (saturated),
      .dbg_state   (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
      end
   endtask

   // driver: waits for in_ready, presents one operation for one accept edge
   task automatic issue(input logic signed [15:0] va, input logic signed [15:0] vb,
                        input logic [3:0] vqs, input logic signed [31:0] vmax,
                        input logic signed [31:0] vmin, input bit push,
                        input logic signed [31:0] eres, input logic edbz,
                        input logic esat, input int elat);
      int waited;
      waited = 0;
      @(posedge clk); #1;
      while (!in_ready && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL issue_timeout actual=in_ready_low expected=in_ready_high");
         return;
      end
      a        = va;
      b        = vb;
      q_shift  = vqs;
      sat_max  = vmax;
      sat_min  = vmin;
      in_valid = 1'b1;
      if (push) begin
         exp_q.push_back({eres, edbz, esat});
         acc_q.push_back(cyc);
         lat_q.push_back(elat);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 300) begin
         @(posedge clk); #1;
         waited++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout actual=%0d pending expected=0 pending", exp_q.size());
      end
   endtask

   // monitor: pops the scoreboard on every output transfer
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      int acc;
      int lat;
      if (rst) begin
         seen_valid = 1'b0;
      end else if (out_valid) begin
         if (!seen_valid) begin
            seen_valid = 1'b1;
            first_cyc  = cyc;
         end
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_output actual=%0d expected=no_output", $signed(result));
            end else begin
               e   = exp_q.pop_front();
               acc = acc_q.pop_front();
               lat = lat_q.pop_front();
               check("result", result, e[33:2]);
               check("div_by_zero", 32'(div_by_zero), 32'(e[1]));
               check("saturated", 32'(saturated), 32'(e[0]));
               check("latency", 32'(first_cyc - acc), 32'(lat));
            end
            seen_valid = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_result", result, 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      check("rst_sat", 32'(saturated), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

      // directed vectors
      issue(16'sd256,    16'sd512, 4'd8,  S_MAX, S_MIN, 1, 32'sd128, 0, 0, 33);
      issue(-16'sd768,   16'sd256, 4'd8,  S_MAX, S_MIN, 1, -32'sd768, 0, 0, 33);
      issue(-16'sd32768, -16'sd1,  4'd15, S_MAX, S_MIN, 1, 32'sd1073741824, 0, 0, 33);
      issue(16'sd32767,  16'sd1,   4'd15, 32'sd1000000, S_MIN, 1, 32'sd1000000, 0, 1, 33);
      issue(16'sd100,    16'sd0,   4'd0,  32'sd12345, -32'sd999, 1, 32'sd12345, 1, 1, 1);
      issue(-16'sd5,     16'sd0,   4'd0,  32'sd12345, -32'sd999, 1, -32'sd999, 1, 1, 1);
      issue(16'sd0,      16'sd0,   4'd3,  32'sd12345, -32'sd999, 1, 32'sd12345, 1, 1, 1);
      issue(16'sd2,      16'sd3,   4'd0,  S_MAX, S_MIN, 1, RND ? 32'sd1 : 32'sd0, 0, 0, 33);
      issue(-16'sd2,     16'sd3,   4'd0,  S_MAX, S_MIN, 1, RND ? -32'sd1 : 32'sd0, 0, 0, 33);
      issue(16'sd7,      16'sd2,   4'd0,  S_MAX, S_MIN, 1, RND ? 32'sd4 : 32'sd3, 0, 0, 33);
      issue(-16'sd7,     16'sd2,   4'd0,  S_MAX, S_MIN, 1, RND ? -32'sd4 : -32'sd3, 0, 0, 33);
      issue(16'sd1000,   -16'sd7,  4'd0,  S_MAX, S_MIN, 1, RND ? -32'sd143 : -32'sd142, 0, 0, 33);
      issue(-16'sd32768, 16'sd1,   4'd4,  S_MAX, -32'sd100000, 1, -32'sd100000, 0, 1, 33);
      issue(16'sd0,      16'sd5,   4'd3,  S_MAX, S_MIN, 1, 32'sd0, 0, 0, 33);
      issue(16'sd100,    16'sd1,   4'd0,  32'sd100, -32'sd100, 1, 32'sd100, 0, 0, 33);
      drain();

      // backpressure: hold DONE for 5 cycles with stray in_valid pulses
      out_ready = 1'b0;
      issue(16'sd300, 16'sd7, 4'd2, S_MAX, S_MIN, 1, 32'sd171, 0, 0, 33);
      begin
         int waited;
         waited = 0;
         while (!out_valid && waited < 100) begin
            @(posedge clk); #1;
            waited++;
         end
      end
      check("bp_out_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         a        = 16'sd1;
         b        = 16'sd1;
         in_valid = (i % 2 == 0);
         @(posedge clk); #1;
         check("bp_hold_result", result, 32'sd171);
         check("bp_hold_flags", {30'd0, div_by_zero, saturated}, 32'd0);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      issue(-16'sd100, 16'sd9, 4'd3, S_MAX, S_MIN, 1, RND ? -32'sd89 : -32'sd88, 0, 0, 33);
      drain();

      // reset in the middle of CALC abandons the operation
      issue(16'sd5000, 16'sd3, 4'd5, S_MAX, S_MIN, 0, 32'sd0, 0, 0, 0);
      repeat (9) @(posedge clk);
      #1;
      check("mid_state_calc", 32'(dbg_state), 32'(ST_CALC));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_result", result, 32'd0);
      check("midrst_dbz", 32'(div_by_zero), 32'd0);
      check("midrst_sat", 32'(saturated), 32'd0);
      issue(16'sd5000, 16'sd3, 4'd5, S_MAX, S_MIN, 1, 32'sd53333, 0, 0, 33);
      drain();

      // report
      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
